// File: rtl/signed_sat_accumulator_if.sv
// Stream bundle for the signed saturating accumulator: one upstream sample
// channel and one downstream frame-result channel. There is no backpressure.
interface signed_sat_accumulator_if #(
    parameter int W = 8
);
    logic                up_valid;
    logic signed [W-1:0] up_data;
    logic                up_last;
    logic                sat_en;

    logic                down_valid;
    logic signed [W-1:0] down_data;
    logic                down_sat;

    // Producer of samples and consumer of frame results.
    modport master (
        output up_valid, up_data, up_last, sat_en,
        input  down_valid, down_data, down_sat
    );

    // The accumulator itself.
    modport slave (
        input  up_valid, up_data, up_last, sat_en,
        output down_valid, down_data, down_sat
    );
endinterface

// File: rtl/signed_sat_accumulator.sv
// Pipelined signed frame accumulator with per-sample saturate/wrap mode.
// Stage 1 registers the sample, stage 2 updates the running frame sum and
// sticky overflow flag, and an output register publishes the finished frame
// sum two edges after its last sample is accepted.
module signed_sat_accumulator #(
    parameter int W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    signed_sat_accumulator_if.slave   bus
);
    localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    // Stage 1 registers
    logic                s1_valid;
    logic signed [W-1:0] s1_data;
    logic                s1_last;
    logic                s1_sat;

    // Stage 2 state
    logic signed [W-1:0] acc;
    logic                ovf_flag;
    logic                frame_start;
    logic                out_pend;

    // Stage 2 combinational step
    logic signed [W-1:0] base;
    logic signed [W-1:0] sum;
    logic                pos_ovf;
    logic                neg_ovf;
    logic signed [W-1:0] step_res;
    logic                step_flag;

    // Stage 1: capture the upstream sample every cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before the edge, independent of order.
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_last  <= 1'b0;
            s1_sat   <= 1'b0;
        end else begin
            s1_valid <= bus.up_valid;
            s1_data  <= bus.up_data;
            s1_last  <= bus.up_last;
            s1_sat   <= bus.sat_en;
        end
    end

    // Stage 2 datapath: add the sample to the running sum and classify overflow.
    always_comb begin
        // NOTE: every output of this block is given a value before any
        // conditional so no path can leave one unassigned and infer a latch.
        base      = frame_start ? '0 : acc;
        // The low W bits of the sign-extended (W+1)-bit sum equal the plain
        // W-bit sum, and overflow is judged from bit W-1 alone.
        sum       = base + s1_data;
        pos_ovf   = !base[W-1] && !s1_data[W-1] &&  sum[W-1];
        neg_ovf   =  base[W-1] &&  s1_data[W-1] && !sum[W-1];
        step_res  = sum;
        if (s1_sat) begin
            if (pos_ovf) begin
                step_res = SAT_MAX;
            end else if (neg_ovf) begin
                step_res = SAT_MIN;
            end
        end
        step_flag = (frame_start ? 1'b0 : ovf_flag) | pos_ovf | neg_ovf;
    end

    // Stage 2 state: commit the step for valid samples, hold through bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= '0;
            ovf_flag    <= 1'b0;
            frame_start <= 1'b1;
            out_pend    <= 1'b0;
        end else begin
            out_pend <= s1_valid && s1_last;
            if (s1_valid) begin
                acc         <= step_res;
                ovf_flag    <= step_flag;
                frame_start <= s1_last;
            end
        end
    end

    // Output register: publish the completed frame sum for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.down_valid <= 1'b0;
            bus.down_data  <= '0;
            bus.down_sat   <= 1'b0;
        end else begin
            bus.down_valid <= out_pend;
            if (out_pend) begin
                bus.down_data <= acc;
                bus.down_sat  <= ovf_flag;
            end
        end
    end
endmodule

// File: tb/tb_signed_sat_accumulator.sv
// Self-checking bench for signed_sat_accumulator at W=4. An integer model
// predicts each frame result and the edge it must appear on; directed frames
// additionally carry hand-computed results.
module tb_signed_sat_accumulator;
    localparam int W    = 4;
    localparam int MAXV = (1 << (W-1)) - 1;
    localparam int MINV = -(1 << (W-1));
    localparam int MODV = 1 << W;

    typedef struct {
        int cyc;
        int data;
        int sat;
    } exp_t;

    typedef struct {
        int data;
        int sat;
    } lit_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    signed_sat_accumulator_if #(.W(W)) bus ();

    signed_sat_accumulator #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int   cyc      = 0;
    int   m_acc    = 0;
    int   m_flag   = 0;
    bit   m_start  = 1'b1;
    exp_t exp_q[$];
    lit_t lit_q[$];
    int   e_valid  = 0;
    int   e_data   = 0;
    int   e_sat    = 0;

    // Model: integer frame sum with range-checked clamp or modular wrap.
    always @(posedge clk) begin
        int base, s, d, res, ovf;
        cyc++;
        if (rst) begin
            m_acc   = 0;
            m_flag  = 0;
            m_start = 1'b1;
            while (exp_q.size() > 0 && exp_q[$].cyc >= cyc) void'(exp_q.pop_back());
            e_valid = 0;
            e_data  = 0;
            e_sat   = 0;
        end else begin
            if (bus.up_valid) begin
                d    = int'($signed(bus.up_data));
                base = m_start ? 0 : m_acc;
                s    = base + d;
                ovf  = (s > MAXV || s < MINV) ? 1 : 0;
                res  = s;
                if (s > MAXV) res = bus.sat_en ? MAXV : s - MODV;
                if (s < MINV) res = bus.sat_en ? MINV : s + MODV;
                m_flag  = (m_start ? 0 : m_flag) | ovf;
                m_acc   = res;
                m_start = bus.up_last;
                if (bus.up_last) exp_q.push_back('{cyc + 2, res, m_flag});
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e_valid = 1;
                e_data  = exp_q[0].data;
                e_sat   = exp_q[0].sat;
                void'(exp_q.pop_front());
            end else begin
                e_valid = 0;
            end
        end
    end

    // Compare: outputs against the model every cycle, plus literal results.
    always @(negedge clk) begin
        lit_t l;
        if (cyc > 0) begin
            check("down_valid", bus.down_valid, e_valid);
            check("down_data", $signed(bus.down_data), e_data);
            check("down_sat", bus.down_sat, e_sat);
            if (bus.down_valid === 1'b1 && lit_q.size() > 0) begin
                l = lit_q.pop_front();
                check("literal_data", $signed(bus.down_data), l.data);
                check("literal_sat", bus.down_sat, l.sat);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input bit v, input int d, input bit last, input bit sat);
        logic [31:0] dv;
        dv           = d;
        bus.up_valid = v;
        bus.up_data  = dv[W-1:0];
        bus.up_last  = last;
        bus.sat_en   = sat;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        bit in_frame;
        bit sat;
        bus.up_valid = 1'b0;
        bus.up_data  = '0;
        bus.up_last  = 1'b0;
        bus.sat_en   = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Saturate mode
        lit_q.push_back('{6, 0});
        send(1, 1, 0, 1); send(1, 2, 0, 1); send(1, 3, 1, 1); idle(4);
        lit_q.push_back('{7, 1});
        send(1, 4, 0, 1); send(1, 7, 1, 1); idle(4);
        lit_q.push_back('{-8, 1});
        send(1, -4, 0, 1); send(1, -7, 1, 1); idle(4);
        lit_q.push_back('{-1, 1});
        send(1, 7, 0, 1); send(1, 7, 0, 1); send(1, -8, 1, 1); idle(4);

        // Wrap mode
        lit_q.push_back('{-5, 1});
        send(1, 4, 0, 0); send(1, 7, 1, 0); idle(4);
        lit_q.push_back('{-2, 0});
        send(1, 3, 0, 0); send(1, -5, 1, 0); idle(4);

        // Back-to-back single-sample frames
        lit_q.push_back('{-8, 0});
        lit_q.push_back('{5, 0});
        send(1, -8, 1, 1); send(1, 5, 1, 1); idle(4);

        // Bubbles inside a frame
        lit_q.push_back('{3, 0});
        send(1, 1, 0, 1); idle(2); send(1, 2, 1, 1); idle(4);

        // Reset mid-frame
        lit_q.push_back('{1, 0});
        send(1, 6, 0, 1); send(1, 6, 0, 1);
        rst = 1'b1; idle(1); rst = 1'b0;
        send(1, 1, 1, 1); idle(5);
        check("literal_queue_drained", lit_q.size(), 0);

        // Randomised frames with occasional resets
        in_frame = 1'b0;
        sat      = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1; idle(1); rst = 1'b0;
                in_frame = 1'b0;
            end else if ($urandom_range(0, 9) < 7) begin
                bit last;
                if (!in_frame) sat = $urandom_range(0, 1) == 1;
                last = $urandom_range(0, 3) == 0;
                send(1, $urandom_range(0, MODV - 1), last, sat);
                in_frame = !last;
            end else begin
                idle(1);
            end
        end
        send(1, 0, 1, sat);
        idle(6);
        check("model_pending_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
